// File: rtl/tlc_phase_scheduler.sv
// Intersection phase scheduler: highway/country lights plus pedestrian crossing, one shared timer.
// Optional emergency preemption (emg_req input, EH state) is enabled by defining EMERGENCY_PREEMPT_EN.
module tlc_phase_scheduler #(
    parameter int MIN_HWY_GREEN    = 8,
    parameter int YELLOW_TIME      = 3,
    parameter int ALL_RED_TIME     = 2,
    parameter int CNTRY_GREEN_TIME = 6,
    parameter int WALK_TIME        = 5,
    parameter int PED_CLEAR_TIME   = 4,
    parameter int CNT_W            = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       car_req,
    input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       emg_req,
`endif
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [1:0] walk,
    output logic       ped_ack,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_HG = 3'd0,
        S_HY = 3'd1,
        S_AR = 3'd2,
        S_CG = 3'd3,
        S_CY = 3'd4,
        S_PW = 3'd5,
`ifdef EMERGENCY_PREEMPT_EN
        S_PC = 3'd6,
        S_EH = 3'd7
`else
        S_PC = 3'd6
`endif
    } state_t;

    typedef enum logic {
        G_CAR = 1'b0,
        G_PED = 1'b1
    } grant_t;

    localparam logic [CNT_W-1:0] HG_LAST   = CNT_W'(MIN_HWY_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] CG_LAST   = CNT_W'(CNTRY_GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_TIME - 1);
    localparam logic [CNT_W-1:0] PC_LAST   = CNT_W'(PED_CLEAR_TIME - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             car_pend_q, car_pend_d;
    logic             ped_pend_q, ped_pend_d;
    grant_t           grant_q, grant_d;
    grant_t           last_grant_q, last_grant_d;
    logic             ret_hg_q, ret_hg_d;

    // emg_now: preempt the running green/walk; emg_go: divert the next all-red exit to EH
    logic emg_now;
    logic emg_go;

`ifdef EMERGENCY_PREEMPT_EN
    logic emg_seq_q, emg_seq_d;

    assign emg_now = emg_req;
    assign emg_go  = emg_req | emg_seq_q;

    always_comb begin
        emg_seq_d = emg_seq_q;
        if (emg_req && (state_q != S_EH)) begin
            emg_seq_d = 1'b1;
        end
        if ((state_d == S_EH) && (state_q != S_EH)) begin
            emg_seq_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            emg_seq_q <= 1'b0;
        end else begin
            emg_seq_q <= emg_seq_d;
        end
    end
`else
    assign emg_now = 1'b0;
    assign emg_go  = 1'b0;
`endif

    // Next-state, grant arbitration and return-path bookkeeping
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ret_hg_d     = ret_hg_q;
        case (state_q)
            S_HG: begin
                if (emg_now) begin
                    state_d  = S_HY;
                    ret_hg_d = 1'b0;
                end else if ((timer_q == HG_LAST) && (car_pend_q || ped_pend_q)) begin
                    state_d  = S_HY;
                    ret_hg_d = 1'b0;
                    if (car_pend_q && ped_pend_q) begin
                        grant_d = (last_grant_q == G_PED) ? G_CAR : G_PED;
                    end else if (car_pend_q) begin
                        grant_d = G_CAR;
                    end else begin
                        grant_d = G_PED;
                    end
                    last_grant_d = grant_d;
                end
            end
            S_HY: begin
                if (timer_q == Y_LAST) begin
                    state_d  = S_AR;
                    ret_hg_d = 1'b0;
                end
            end
            S_AR: begin
                if (timer_q == AR_LAST) begin
`ifdef EMERGENCY_PREEMPT_EN
                    if (emg_go) begin
                        state_d = S_EH;
                    end else
`endif
                    if (ret_hg_q) begin
                        state_d = S_HG;
                    end else if (grant_q == G_CAR) begin
                        state_d = S_CG;
                    end else begin
                        state_d = S_PW;
                    end
                end
            end
            S_CG: begin
                if (emg_now || (timer_q == CG_LAST)) begin
                    state_d = S_CY;
                end
            end
            S_CY: begin
                if (timer_q == Y_LAST) begin
                    state_d  = S_AR;
                    ret_hg_d = 1'b1;
                end
            end
            S_PW: begin
                if (emg_now || (timer_q == WALK_LAST)) begin
                    state_d = S_PC;
                end
            end
            S_PC: begin
                if (timer_q == PC_LAST) begin
                    state_d  = S_AR;
                    ret_hg_d = 1'b1;
                end
            end
`ifdef EMERGENCY_PREEMPT_EN
            S_EH: begin
                if (!emg_req) begin
                    state_d = S_HG;
                end
            end
`endif
            default: begin
                state_d = S_HG;
            end
        endcase
    end

    // Timer restarts on every state change; HG holds at its minimum so a late request is served at once
    always_comb begin
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == S_HG) && (timer_q == HG_LAST)) begin
            timer_d = timer_q;
`ifdef EMERGENCY_PREEMPT_EN
        end else if (state_q == S_EH) begin
            timer_d = timer_q;
`endif
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Requests are latched except while their own phase is being served; clearing wins on entry
    always_comb begin
        car_pend_d = car_pend_q;
        ped_pend_d = ped_pend_q;
        if (car_req && (state_q != S_CG) && (state_q != S_CY)) begin
            car_pend_d = 1'b1;
        end
        if (ped_req && (state_q != S_PW) && (state_q != S_PC)) begin
            ped_pend_d = 1'b1;
        end
        if ((state_d == S_CG) && (state_q != S_CG)) begin
            car_pend_d = 1'b0;
        end
        if ((state_d == S_PW) && (state_q != S_PW)) begin
            ped_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q      <= S_HG;
            timer_q      <= '0;
            car_pend_q   <= 1'b0;
            ped_pend_q   <= 1'b0;
            grant_q      <= G_CAR;
            last_grant_q <= G_PED;
            ret_hg_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            car_pend_q   <= car_pend_d;
            ped_pend_q   <= ped_pend_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ret_hg_q     <= ret_hg_d;
        end
    end

    // Moore light decode: any state not listed shows all-red with DONT_WALK
    always_comb begin
        hwy   = 2'd0;
        cntry = 2'd0;
        walk  = 2'd0;
        case (state_q)
            S_HG:    hwy   = 2'd2;
            S_HY:    hwy   = 2'd1;
            S_CG:    cntry = 2'd2;
            S_CY:    cntry = 2'd1;
            S_PW:    walk  = 2'd2;
            S_PC:    walk  = 2'd1;
            default: hwy   = 2'd0;
        endcase
    end

    assign ped_ack = (state_q == S_PW) && (timer_q == '0);
    assign state   = state_q;

endmodule

// File: doc/tlc_phase_scheduler.md
Name: tlc_phase_scheduler

Overview:
Intersection phase scheduler that sequences the highway/country traffic lights plus a pedestrian crossing. It latches requests from the country-road car sensor and the pedestrian button, and arbitrates between them. It enforces minimum highway green, yellow, all-red clearance and walk timing from one cycle-counting timer. It sits above the light drivers and replaces direct sensor-to-FSM wiring.

Parameters:
MIN_HWY_GREEN, 8, minimum highway-green cycles before a request is served
YELLOW_TIME, 3, cycles in any yellow state
ALL_RED_TIME, 2, cycles in all-red clearance
CNTRY_GREEN_TIME, 6, cycles of country green
WALK_TIME, 5, cycles of pedestrian WALK
PED_CLEAR_TIME, 4, cycles of flashing DONT_WALK
CNT_W, 8, timer width; every *_TIME must be >=1 and <2^CNT_W

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-low reset (0 = reset)
car_req  input  1  country-road car sensor (X), level
ped_req  input  1  pedestrian button, level or pulse
hwy  output  2  highway light: 0 RED, 1 YELLOW, 2 GREEN
cntry  output  2  country light, same encoding
walk  output  2  ped signal: 0 DONT_WALK, 1 FLASH_DONT_WALK, 2 WALK
ped_ack  output  1  one-cycle pulse on the first cycle of PW
state  output  3  current state code (debug)

Behaviour:
- One clock; reset is asynchronous and active-low on clear.
- Reset values:
  - state=HG(0), timer=0, car_pend=0, ped_pend=0, last_grant=PED, ret_hg=0.
  - Outputs: hwy=2, cntry=0, walk=0, ped_ack=0.
- States (code): HG 0, HY 1, AR 2, CG 3, CY 4, PW 5, PC 6, EH 7 (EH only with the optional feature).
- Timer:
  - Cleared on every state change; increments by 1 each cycle otherwise.
  - A state with duration D exits when timer==D-1, so it lasts exactly D cycles.
  - In HG the timer saturates at MIN_HWY_GREEN-1.
- Pending latches:
  - car_pend sets when car_req=1, except in CG/CY, where car_req is ignored.
  - ped_pend sets when ped_req=1, except in PW/PC.
  - car_pend clears on the transition into CG; ped_pend clears on the transition into PW.
- HG -> HY when timer==MIN_HWY_GREEN-1 and (car_pend|ped_pend). The grant is registered at this transition:
  - only one pending: grant that one;
  - both pending: grant the opposite of last_grant (reset value PED, so car wins first); update last_grant.
- HY -> AR after YELLOW_TIME, with ret_hg=0.
- AR -> after ALL_RED_TIME:
  - if ret_hg=1: HG;
  - else: CG when grant=CAR, PW when grant=PED.
- CG -> CY after CNTRY_GREEN_TIME.
- CY -> AR after YELLOW_TIME, with ret_hg=1.
- PW -> PC after WALK_TIME; PC -> AR after PED_CLEAR_TIME, with ret_hg=1.
- Outputs are Moore, decoded combinationally from state:
  - HG: hwy=2, cntry=0, walk=0
  - HY: hwy=1, cntry=0, walk=0
  - AR: hwy=0, cntry=0, walk=0
  - CG: hwy=0, cntry=2, walk=0
  - CY: hwy=0, cntry=1, walk=0
  - PW: hwy=0, cntry=0, walk=2
  - PC: hwy=0, cntry=0, walk=1
  - EH: hwy=0, cntry=0, walk=0
- Never cntry!=0 while hwy!=0; never walk!=0 unless hwy==0 and cntry==0.
- A request arriving during the other phase's service is held pending and served after returning through HG. HG still enforces its minimum green before serving it.
- Reset asserted mid-phase: immediate return to reset values; pending requests are discarded.

Optional Feature:
EMERGENCY_PREEMPT_EN
- Defined:
  - Adds input emg_req (1 bit, level).
  - From HG or CG, emg_req=1 forces the corresponding yellow (HY/CY) on the next cycle, then AR for ALL_RED_TIME, then EH.
  - From HY, CY or AR, the current timing completes and AR leads to EH.
  - From PW or PC, the sequence goes PC (full duration, entered if not already there), then AR, then EH.
  - EH holds all-red while emg_req=1.
  - On emg_req=0: EH -> HG with timer=0. Pending latches are preserved.
- Undefined: no emg_req port, no EH state; state code 7 is unreachable.

Test Plan:
- Release reset, hold car_req=ped_req=0 for 50 cycles -> state=0, hwy=2, cntry=0, walk=0 throughout.
- 1-cycle car_req pulse on cycle 2 after reset release -> HG ends after 8 cycles, then HY 3, AR 2, CG 6, CY 3, AR 2, then HG; cntry=2 for exactly 6 cycles; car_pend=0 afterwards.
- car_req and ped_req asserted on the same cycle -> CG is served first; HG lasts 8 cycles; then PW 5 cycles with ped_ack pulsing once, walk=2, then PC 4 cycles with walk=1.
- Hold car_req=1 continuously -> CG is repeated each cycle set, with a full HG of 8 cycles between each; car_req is ignored during CG/CY.
- Assert clear=0 in the 3rd cycle of CG -> outputs go to hwy=2, cntry=0, walk=0 asynchronously; after release, no car service occurs without a new request.
- With EMERGENCY_PREEMPT_EN, emg_req=1 during CG -> CY 3, AR 2, EH held; on release go to HG with timer=0.
- With EMERGENCY_PREEMPT_EN, a pending ped_req during preemption is served after the 8-cycle HG.
